// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: holds the PC, runs one imem read per instruction and hands {inst, pc} to decode.
// Optional build macro IFU_ACCESS_FAULT_EN substitutes ebreak and raises if_fault on an imem access error.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        if_ready,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerr,
  output logic        if_fault
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    IDLE  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        run_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic        pc_load;
  logic        inst_load;

  // run_q keeps the request low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (pc_load) begin
        pc_q <= dnpc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    inst_load = 1'b0;
    case (state_q)
      REQ: begin
        if (run_q && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          inst_load = 1'b1;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (dnpc_valid) begin
          pc_load = 1'b1;
          state_d = REQ;
        end else if (id_ready) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (dnpc_valid) begin
          pc_load = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

`ifdef IFU_ACCESS_FAULT_EN
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  logic fault_q;

  always_comb begin
    inst_d = imem_rerr ? EBREAK_INST : imem_rdata;
  end

  // Fault flag lives from the faulting response until the next PC is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (inst_load) begin
      fault_q <= imem_rerr;
    end else if (pc_load) begin
      fault_q <= 1'b0;
    end
  end

  assign if_fault = fault_q;
`else
  logic unused_rerr;

  always_comb begin
    inst_d = imem_rdata;
  end

  assign unused_rerr = imem_rerr;
  assign if_fault    = 1'b0;
`endif

  // Instruction word is data only; its output is masked to NOP outside VALID.
  always_ff @(posedge clk) begin
    if (inst_load) begin
      inst_q <= inst_d;
    end
  end

  assign if_valid  = (state_q == VALID);
  assign if_ready  = (state_q == VALID) || (state_q == IDLE);
  assign inst      = (state_q == VALID) ? inst_q : NOP_INST;
  assign pc        = pc_q;
  assign imem_req  = (state_q == REQ) && run_q;
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a transaction-level model tracks what fetch must present, plus literal spot checks.
module tb_ifu_fetch;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dnpc_valid = 1'b0;
  logic [31:0] dnpc = '0;
  logic        if_ready, if_valid;
  logic        id_ready = 1'b0;
  logic [31:0] inst, pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_rerr = 1'b0;
  logic        if_fault;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .dnpc_valid(dnpc_valid), .dnpc(dnpc),
    .if_ready(if_ready), .if_valid(if_valid), .id_ready(id_ready),
    .inst(inst), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_rerr(imem_rerr), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: what has been asked for / granted / delivered / consumed, per the fetch contract.
  logic [31:0] m_pc, m_inst;
  logic        m_fault, m_started, m_need_req, m_in_flight, m_held, m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_inst <= NOP; m_fault <= 1'b0; m_started <= 1'b0;
      m_need_req <= 1'b1; m_in_flight <= 1'b0; m_held <= 1'b0; m_idle <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (m_need_req && imem_gnt) begin
      m_need_req <= 1'b0; m_in_flight <= 1'b1;
    end else if (m_in_flight && imem_rvalid) begin
      m_in_flight <= 1'b0; m_held <= 1'b1;
`ifdef IFU_ACCESS_FAULT_EN
      m_inst  <= imem_rerr ? EBRK : imem_rdata;
      m_fault <= imem_rerr;
`else
      m_inst  <= imem_rdata;
      m_fault <= 1'b0;
`endif
    end else if ((m_held || m_idle) && dnpc_valid) begin
      m_pc <= dnpc; m_held <= 1'b0; m_idle <= 1'b0; m_need_req <= 1'b1; m_fault <= 1'b0;
    end else if (m_held && id_ready) begin
      m_held <= 1'b0; m_idle <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && imem_req && imem_gnt) hs_cnt <= hs_cnt + 1;
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m_req",   {31'b0, imem_req}, {31'b0, m_started && m_need_req});
      chk("m_addr",  imem_addr, m_pc);
      chk("m_pc",    pc, m_pc);
      chk("m_valid", {31'b0, if_valid}, {31'b0, m_held});
      chk("m_ready", {31'b0, if_ready}, {31'b0, m_held || m_idle});
      chk("m_inst",  inst, m_held ? m_inst : NOP);
      chk("m_fault", {31'b0, if_fault}, {31'b0, m_fault});
    end
  end

  task automatic mem_fetch(input logic [31:0] data, input int gd, input int rd, input logic err);
    imem_gnt = 1'b0;
    repeat (gd) @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (rd) @(negedge clk);
    chk("pre_rvalid_valid", {31'b0, if_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = data; imem_rerr = err;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rerr = 1'b0;
  endtask

  task automatic take_dnpc(input logic [31:0] npc);
    dnpc_valid = 1'b1; dnpc = npc; id_ready = 1'b1;
    @(negedge clk);
    dnpc_valid = 1'b0; id_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_ready", {31'b0, if_ready}, 32'd0);
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_pc",    pc, RPC);
    chk("rst_inst",  inst, NOP);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h8000_0000);
    mem_fetch(32'h0000_0293, 0, 0, 1'b0);
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc",    pc, 32'h8000_0000);
    chk("first_inst",  inst, 32'h0000_0293);

    // Decode back-pressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, if_valid}, 32'd1);
      chk("bp_inst",  inst, 32'h0000_0293);
      chk("bp_req",   {31'b0, imem_req}, 32'd0);
    end
    take_dnpc(32'h8000_0004);
    chk("bp_next_req",  {31'b0, imem_req}, 32'd1);
    chk("bp_next_addr", imem_addr, 32'h8000_0004);

    // Memory stalls
    mem_fetch(32'h00A0_0513, 3, 4, 1'b0);
    chk("stall_valid", {31'b0, if_valid}, 32'd1);
    chk("stall_inst",  inst, 32'h00A0_0513);
    chk("stall_hs",    hs_cnt, 32'd2);

    // IDLE path
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    chk("idle_valid", {31'b0, if_valid}, 32'd0);
    chk("idle_ready", {31'b0, if_ready}, 32'd1);
    chk("idle_inst",  inst, NOP);
    @(negedge clk);
    take_dnpc(32'h8000_0100);
    chk("idle_addr", imem_addr, 32'h8000_0100);
    mem_fetch(32'h0010_0093, 1, 0, 1'b0);
    chk("idle_pc", pc, 32'h8000_0100);

    // Misaligned PC forwarded; dnpc offered while in REQ is ignored
    take_dnpc(32'h8000_0102);
    chk("mis_addr", imem_addr, 32'h8000_0102);
    dnpc_valid = 1'b1; dnpc = 32'h0000_1234;
    @(negedge clk);
    dnpc_valid = 1'b0;
    chk("req_dnpc_ignored", imem_addr, 32'h8000_0102);
    mem_fetch(32'h1111_1111, 0, 2, 1'b0);
    chk("mis_inst", inst, 32'h1111_1111);

    // Access fault
    take_dnpc(32'h8000_0200);
    mem_fetch(32'hDEAD_BEEF, 0, 0, 1'b1);
`ifdef IFU_ACCESS_FAULT_EN
    chk("fault_inst", inst, 32'h0010_0073);
    chk("fault_flag", {31'b0, if_fault}, 32'd1);
`else
    chk("fault_inst", inst, 32'hDEAD_BEEF);
    chk("fault_flag", {31'b0, if_fault}, 32'd0);
`endif
    take_dnpc(32'h8000_0204);
    chk("fault_clear", {31'b0, if_fault}, 32'd0);
    mem_fetch(32'h0000_0613, 0, 1, 1'b0);
    chk("post_fault_inst", inst, 32'h0000_0613);

    // Async reset while waiting for read data
    take_dnpc(32'h8000_0300);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req}, 32'd0);
    chk("ar_valid", {31'b0, if_valid}, 32'd0);
    chk("ar_ready", {31'b0, if_ready}, 32'd0);
    chk("ar_pc",    pc, RPC);
    chk("ar_inst",  inst, NOP);
    chk("ar_fault", {31'b0, if_fault}, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    rst_n = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("ar_stale_valid", {31'b0, if_valid}, 32'd0);
    chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
    chk("ar_restart_addr", imem_addr, RPC);
    mem_fetch(32'h0000_0517, 0, 0, 1'b0);
    chk("ar_inst_new", inst, 32'h0000_0517);
    chk("ar_pc_new",   pc, RPC);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
